// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and imem requester feeding IF/ID, with branch redirect and freeze.
// Define IF_FETCH_BUF_EN to capture a response that arrives during freeze instead of refetching it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic [31:0] pc_out
);
`ifdef IF_FETCH_BUF_EN
  typedef enum logic [1:0] {RUN, DISCARD, HOLD} state_t;
  logic [31:0] r_buf;
`else
  typedef enum logic {RUN, DISCARD} state_t;
`endif
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic        w_take;
  logic        w_hold;
  logic [31:0] w_buf;

  assign w_take = Br_taken & ~freeze;
`ifdef IF_FETCH_BUF_EN
  assign w_hold = r_state == HOLD;
  assign w_buf  = r_buf;
`else
  assign w_hold = 1'b0;
  assign w_buf  = '0;
`endif

  always_comb begin
    imem_req    = ~rst & ~w_hold;
    imem_addr   = r_pc;
    pc_out      = r_pc;
    inst_valid  = ~rst & ((r_state == RUN & imem_ready & ~freeze & ~Br_taken) | (w_hold & ~w_take));
    instruction = inst_valid ? (w_hold ? w_buf : imem_rdata) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
      r_pend  <= '0;
`ifdef IF_FETCH_BUF_EN
      r_buf   <= '0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          if (imem_ready & ~freeze)
            r_pc <= Br_taken ? Br_target : r_pc + PC_STEP;
          else if (w_take) begin
            r_pend  <= Br_target;
            r_state <= DISCARD;
          end
`ifdef IF_FETCH_BUF_EN
          else if (imem_ready) begin
            r_buf   <= imem_rdata;
            r_state <= HOLD;
          end
`endif
        end
        // the outstanding request must complete before the redirect takes effect
        DISCARD: begin
          if (w_take)
            r_pend <= Br_target;
          if (imem_ready) begin
            r_pc    <= w_take ? Br_target : r_pend;
            r_state <= RUN;
          end
        end
`ifdef IF_FETCH_BUF_EN
        HOLD: begin
          if (~freeze) begin
            r_pc    <= Br_taken ? Br_target : r_pc + PC_STEP;
            r_state <= RUN;
          end
        end
`endif
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed stimulus with a queue of expected fetches checked by a negedge monitor.
module tb_if_fetch_stage;
  logic        clk = 0;
  logic        rst, freeze, Br_taken, imem_ready, imem_req, inst_valid;
  logic [31:0] Br_target, imem_addr, imem_rdata, instruction, pc_out;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  exp_t q[$];

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Br_taken(Br_taken), .Br_target(Br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .inst_valid(inst_valid), .pc_out(pc_out)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr + 32'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc = pc;
    e.ins = ins;
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic f, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    imem_ready = r;
    freeze = f;
    Br_taken = b;
    Br_target = t;
  endtask

  always @(negedge clk) begin
    if (inst_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_fetch pc_out=%h instruction=%h required=no valid word", pc_out, instruction);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fetch_pc", pc_out, e.pc);
        chk("fetch_word", instruction, e.ins);
      end
    end
  end

  initial begin
    rst = 1; imem_ready = 1; freeze = 0; Br_taken = 0; Br_target = 0;
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    // sequential fetch with ready tied high
    @(posedge clk); #1; rst = 0; push(32'h0, 32'h1);
    drive(1, 0, 0, 0); push(32'h4, 32'h5);
    drive(1, 0, 0, 0); push(32'h8, 32'h9);
    // ready delayed two cycles at pc=12
    drive(0, 0, 0, 0);
    @(negedge clk); chk("wait_addr0", imem_addr, 32'hC);
    drive(0, 0, 0, 0);
    @(negedge clk); chk("wait_addr1", imem_addr, 32'hC); chk("wait_valid", {31'd0, inst_valid}, 32'd0);
    drive(1, 0, 0, 0); push(32'hC, 32'hD);
    // redirect while pc=16 waits; second redirect in DISCARD overwrites target
    drive(0, 0, 1, 32'h30);
    @(negedge clk); chk("br_wait_addr", imem_addr, 32'h10);
    drive(0, 0, 1, 32'h40);
    @(negedge clk); chk("discard_addr", imem_addr, 32'h10);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0); push(32'h40, 32'h41);
    @(negedge clk); chk("redirect_addr", imem_addr, 32'h40);
    // freeze three cycles with ready high at pc=0x44
    drive(1, 1, 0, 0);
    @(negedge clk); chk("frz_req", {31'd0, imem_req}, 32'd1); chk("frz_addr", imem_addr, 32'h44);
`ifdef IF_FETCH_BUF_EN
    drive(1, 1, 0, 0); push(32'h44, 32'h45);
    @(negedge clk); chk("hold_req", {31'd0, imem_req}, 32'd0);
    drive(1, 1, 0, 0); push(32'h44, 32'h45);
    drive(1, 0, 0, 0); push(32'h44, 32'h45);
`else
    drive(1, 1, 0, 0);
    @(negedge clk); chk("refetch_addr", imem_addr, 32'h44);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0); push(32'h44, 32'h45);
`endif
    // branch under freeze ignored, then taken branch to 0x80
    drive(0, 1, 1, 32'h99);
    drive(0, 0, 0, 0);
    @(negedge clk); chk("frz_br_ignored", imem_addr, 32'h48);
    drive(1, 0, 1, 32'h80);
    drive(1, 0, 0, 0); push(32'h80, 32'h81);
    @(negedge clk); chk("br_addr", imem_addr, 32'h80);
    // reset pulse while discarding
    drive(0, 0, 1, 32'h200);
    drive(0, 0, 0, 0);
    @(posedge clk); #1; rst = 1;
    @(negedge clk);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc_out", pc_out, 32'h0);
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    @(posedge clk); #1; rst = 0; imem_ready = 1; push(32'h0, 32'h1);
    // wrap from the top of the address space
    drive(1, 0, 1, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0); push(32'hFFFF_FFFC, 32'hFFFF_FFFD);
    drive(1, 0, 0, 0); push(32'h0, 32'h1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("pending_expected", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
